muldiv_wb_unit: RTL and testbench



---
 rtl/muldiv_wb_unit_if.sv | 24 ++
 rtl/muldiv_wb_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_wb_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/muldiv_wb_unit_if.sv
// rtl/muldiv_wb_unit_if.sv - execute-side request and register-file write bundle for muldiv_wb_unit
interface muldiv_wb_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             regWrite;
  logic [WIDTH-1:0] wrData;
  logic             R15write;
  logic [WIDTH-1:0] wrR15_Data;
  logic             div_by_zero;

  modport master (
    output start, op_div, op_a, op_b,
    input  busy, done, regWrite, wrData, R15write, wrR15_Data, div_by_zero
  );

  modport slave (
    input  start, op_div, op_a, op_b,
    output busy, done, regWrite, wrData, R15write, wrR15_Data, div_by_zero
  );
endinterface

// File: rtl/muldiv_wb_unit.sv
// rtl/muldiv_wb_unit.sv - iterative signed 16-bit multiply/divide feeding the rd and R15 write ports
module muldiv_wb_unit #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_OPS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_wb_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        div_q, neg_a_q, neg_b_q, dz_q;
  logic [15:0] a_q;
  logic [15:0] m_q;
  logic [16:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] wr_data_q, wr_r15_q;

  logic        sign_a, sign_b;
  logic [15:0] mag_a, mag_b;
  logic [16:0] sum, shifted;
  logic [17:0] diff;
  logic [31:0] prod, prod_fix;
  logic [15:0] fix_lo, fix_hi;

  assign sign_a = SIGNED_OPS && bus.op_a[15];
  assign sign_b = SIGNED_OPS && bus.op_b[15];
  assign mag_a  = sign_a ? (~bus.op_a + 16'd1) : bus.op_a;
  assign mag_b  = sign_b ? (~bus.op_b + 16'd1) : bus.op_b;

  // hi_q is the running upper product (MUL) or partial remainder (DIV); lo_q
  // shifts out multiplier bits or dividend bits and shifts in quotient bits.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = {1'b0, hi_q[15:0]} + (lo_q[0] ? {1'b0, m_q} : 17'd0);
    shifted = {hi_q[15:0], lo_q[15]};
    diff    = {1'b0, shifted} - {2'b00, m_q};
    if (div_q) begin
      if (!diff[17]) begin
        hi_d = diff[16:0];
        lo_d = {lo_q[14:0], 1'b1};
      end else begin
        hi_d = shifted;
        lo_d = {lo_q[14:0], 1'b0};
      end
    end else begin
      hi_d = {1'b0, sum[16:1]};
      lo_d = {sum[0], lo_q[15:1]};
    end
  end

  always_comb begin
    prod     = {hi_q[15:0], lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 32'd1) : prod;
    fix_lo   = prod_fix[15:0];
    fix_hi   = prod_fix[31:16];
    if (div_q) begin
      fix_lo = (neg_a_q ^ neg_b_q) ? (~lo_q + 16'd1) : lo_q;
      fix_hi = neg_a_q ? (~hi_q[15:0] + 16'd1) : hi_q[15:0];
      // A zero divisor reports the raw dividend back on the R15 port.
      if (dz_q) begin
        fix_lo = 16'h0000;
        fix_hi = a_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 4'd0;
      div_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= 16'h0000;
      m_q       <= 16'h0000;
      hi_q      <= 17'd0;
      lo_q      <= 16'h0000;
      wr_data_q <= 16'h0000;
      wr_r15_q  <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          div_q   <= bus.op_div;
          a_q     <= bus.op_a;
          neg_a_q <= sign_a;
          neg_b_q <= sign_b;
          dz_q    <= bus.op_div && (bus.op_b == 16'h0000);
          cnt_q   <= 4'd15;
          hi_q    <= 17'd0;
          m_q     <= bus.op_div ? mag_b : mag_a;
          lo_q    <= bus.op_div ? mag_a : mag_b;
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 4'd1;
        end
        S_FIX: begin
          wr_data_q <= fix_lo;
          wr_r15_q  <= fix_hi;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 4'd0) state_d = S_FIX;
      S_FIX:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_WRITE);
    bus.regWrite    = (state_q == S_WRITE) && !dz_q;
    bus.R15write    = (state_q == S_WRITE) && !dz_q;
    bus.div_by_zero = (state_q == S_WRITE) && dz_q;
    bus.wrData      = wr_data_q;
    bus.wrR15_Data  = wr_r15_q;
  end

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// tb/tb_muldiv_wb_unit.sv - directed-vector bench for muldiv_wb_unit
module tb_muldiv_wb_unit;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muldiv_wb_unit_if #(.WIDTH(16)) bus ();

  muldiv_wb_unit #(.WIDTH(16), .SIGNED_OPS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE and check the WRITE cycle contents.
  task automatic run_op(input string tag, input logic div, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_lo, input logic [15:0] exp_hi, input logic exp_dz);
    int lat;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = div;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 16'($urandom);
    bus.op_b  = 16'($urandom);
    bus.op_div = ~div;
    check({tag, "_busy"}, bus.busy, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 40);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_busy_w"}, bus.busy, 1'b1);
    check({tag, "_regWrite"}, bus.regWrite, !exp_dz);
    check({tag, "_R15write"}, bus.R15write, !exp_dz);
    check({tag, "_dz"}, bus.div_by_zero, exp_dz);
    check({tag, "_wrData"}, bus.wrData, exp_lo);
    check({tag, "_wrR15"}, bus.wrR15_Data, exp_hi);
    @(negedge clk);
    check({tag, "_done_end"}, bus.done, 1'b0);
    check({tag, "_busy_end"}, bus.busy, 1'b0);
    check({tag, "_hold"}, bus.wrData, exp_lo);
  endtask

  initial begin
    int first_done, second_done, busy_low, cyc, writes;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op_div = 1'b0;
    bus.op_a = 16'h0000;
    bus.op_b = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_wrData", bus.wrData, 16'h0000);
    check("reset_wrR15", bus.wrR15_Data, 16'h0000);
    rst = 1'b1;

    run_op("mul_basic", 1'b0, 16'h0051, 16'h0011, 16'h0561, 16'h0000, 1'b0);
    run_op("mul_neg",   1'b0, 16'hFF88, 16'h0002, 16'hFF10, 16'hFFFF, 1'b0);
    run_op("mul_max",   1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0);
    run_op("div_basic", 1'b1, 16'h3099, 16'h0011, 16'h02DB, 16'h000E, 1'b0);
    run_op("div_neg",   1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    run_op("div_ovf",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    run_op("div_zero",  1'b1, 16'h6666, 16'h0000, 16'h0000, 16'h6666, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b0; bus.op_a = 16'h1234; bus.op_b = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);
    check("rst_mid_regWrite", bus.regWrite, 1'b0);
    check("rst_mid_R15write", bus.R15write, 1'b0);
    check("rst_mid_dz", bus.div_by_zero, 1'b0);
    check("rst_mid_wrData", bus.wrData, 16'h0000);
    check("rst_mid_wrR15", bus.wrR15_Data, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    writes = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.regWrite || bus.R15write) writes++;
    end
    check("rst_no_write", writes, 0);
    run_op("post_rst", 1'b0, 16'h0051, 16'h0011, 16'h0561, 16'h0000, 1'b0);

    // Start pulses during CALC and during WRITE are dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b0; bus.op_a = 16'h0002; bus.op_b = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("drop_wrData", bus.wrData, 16'h0006);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("drop_write_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("drop_write_busy2", bus.busy, 1'b0);

    // start held high: back-to-back operations 19 cycles apart.
    bus.start = 1'b1; bus.op_div = 1'b1; bus.op_a = 16'h0064; bus.op_b = 16'h0007;
    first_done = -1; second_done = -1; busy_low = 0;
    for (int i = 0; i < 70 && second_done < 0; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end else if (first_done >= 0 && !bus.busy) begin
        busy_low++;
      end
    end
    bus.start = 1'b0;
    check("b2b_period", second_done - first_done, 19);
    check("b2b_busy_low", busy_low, 1);
    check("b2b_wrData", bus.wrData, 16'h000E);
    check("b2b_wrR15", bus.wrR15_Data, 16'h0002);
    repeat (25) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
